board_tracker: RTL and testbench
================================

Name: board_tracker

Overview:
- Sequential, parametrised NxN game-board engine for the tic-tac-toe datapath.
- Holds the board state and accepts moves over a valid/ready handshake.
- Enforces legality and turn order, counts moves, and flags full-board, winner and game-over after every accepted move.
- Sits between the input/move controller and the display/result logic; its full-board flag supersedes the standalone combinational full check.

Parameters:
N, 3, board side length; board has N*N cells, winning line is N identical marks (N>=3)
IDXW, $clog2(N*N), width of cell index (derived, not overridden)
CW, $clog2(N*N+1), width of move counter (derived, not overridden)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
clear  input  1  synchronous new-game request, highest priority
move_valid  input  1  move request present
move_ready  output  1  block can accept a move
move_idx  input  IDXW  target cell, idx = row*N + col
move_player  input  2  mover code: 01 = player 1, 10 = player 2
resp_valid  output  1  one-cycle pulse carrying the result of a move
resp_err  output  3  result code, valid with resp_valid
board_flat  output  2*N*N  cell i at [2i+1:2i]; 00 empty, 01 P1, 10 P2
next_player  output  2  player expected to move next
move_count  output  CW  number of legal moves placed
is_full  output  1  every cell occupied
winner  output  2  00 none, else code of the winning player
game_over  output  1  winner != 00 or is_full

Behaviour:
- Reset (rst_n low, async) values: board all 00, next_player 01, move_count 0, is_full 0, winner 00, game_over 0, resp_valid 0, resp_err 0, state IDLE.
- FSM has three states:
  - IDLE: move_ready=1. On move_valid&&move_ready (cycle T), capture the request, compute legality, go to UPD.
  - UPD (T+1): move_ready=0. If legal: write the cell, toggle next_player, move_count+1. Go to CHK.
  - CHK (T+2): move_ready=0. Update is_full (move_count==N*N), winner and game_over from the registered board. Pulse resp_valid with resp_err. Return to IDLE.
- Fixed latency: the request is accepted at T, and resp_valid plus the updated flags appear at T+2. The next accept is possible at T+3.
- Illegal moves still traverse UPD and CHK with the same latency; board, counter and turn stay unchanged.
- resp_err codes, checked in priority order (highest first):
  - 5: game_over already set
  - 4: move_player is 00 or 11
  - 2: move_idx >= N*N
  - 3: move_player != next_player
  - 1: target cell occupied
  - 0: OK
- Win detection covers N rows, N columns, the main diagonal (idx i*(N+1)) and the anti-diagonal (idx (i+1)*(N-1)). Only the mover can complete a line, so winner takes the mover's code.
- Final move that both wins and fills the board: winner set, is_full=1, game_over=1.
- Once game_over=1, every later move returns err 5 until clear or reset.
- move_count saturates by construction at N*N, since a full board sets game_over.
- clear:
  - Sampled every cycle in any state.
  - Next cycle returns all outputs to their reset values and the state to IDLE.
  - A clear in UPD or CHK aborts the move with no resp_valid pulse.
  - A clear coinciding with move_valid in IDLE wins; the move is not accepted.
- The move_* inputs are only sampled at the accept cycle and may change afterwards.

Test Plan:
- N=3, reset, then P1 at idx 0 -> accepted T, resp_valid at T+2 with err 0; board_flat[1:0]=01, move_count=1, next_player=10.
- P1 moves twice in a row -> second response err 3; board and move_count unchanged; next latency still 2 cycles.
- P1 at 4, P2 at 4 -> second response err 1; idx 9 with the correct player -> err 2; move_player=11 -> err 4.
- Sequence P1:0, P2:3, P1:1, P2:4, P1:2 -> last resp err 0, winner=01, game_over=1, is_full=0; a further move -> err 5.
- Draw sequence 0,1,2,4,3,5,7,6,8 with alternating players -> after the 9th move is_full=1, winner=00, game_over=1, move_count=9.
- clear asserted in UPD -> no resp_valid; next cycle board all 00, move_count 0, next_player 01. Async rst_n pulse mid-CHK -> immediate reset values. N=4 anti-diagonal idx 3,6,9,12 won by P2 -> winner=10.

Source files
------------

// File: rtl/board_tracker.sv
// NxN tic-tac-toe board engine: holds the board, validates moves taken over a
// valid/ready handshake, and reports result codes plus full/winner/game-over flags.
module board_tracker #(
  parameter int N = 3,
  localparam int IDXW = $clog2(N*N),
  localparam int CW = $clog2(N*N+1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              move_valid,
  output logic              move_ready,
  input  logic [IDXW-1:0]   move_idx,
  input  logic [1:0]        move_player,
  output logic              resp_valid,
  output logic [2:0]        resp_err,
  output logic [2*N*N-1:0]  board_flat,
  output logic [1:0]        next_player,
  output logic [CW-1:0]     move_count,
  output logic              is_full,
  output logic [1:0]        winner,
  output logic              game_over
);

  localparam int CELLS = N*N;
  localparam logic [CW-1:0] FULL_CNT = CW'(CELLS);
  localparam logic [2:0] ERR_OK    = 3'd0;
  localparam logic [2:0] ERR_OCC   = 3'd1;
  localparam logic [2:0] ERR_RANGE = 3'd2;
  localparam logic [2:0] ERR_TURN  = 3'd3;
  localparam logic [2:0] ERR_PLYR  = 3'd4;
  localparam logic [2:0] ERR_OVER  = 3'd5;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_UPD = 2'd1, S_CHK = 2'd2} state_e;

  state_e               state_q, state_d;
  logic [2*CELLS-1:0]   board_q, board_d;
  logic [1:0]           next_player_q, next_player_d;
  logic [CW-1:0]        move_count_q, move_count_d;
  logic                 is_full_q, is_full_d;
  logic [1:0]           winner_q, winner_d;
  logic                 game_over_q, game_over_d;
  logic                 resp_valid_q, resp_valid_d;
  logic [2:0]           resp_err_q, resp_err_d;
  logic [IDXW-1:0]      req_idx_q, req_idx_d;
  logic [1:0]           req_player_q, req_player_d;
  logic [2:0]           req_err_q, req_err_d;

  function automatic logic has_line(input logic [2*CELLS-1:0] b, input logic [1:0] p);
    logic hit, row_ok, col_ok, diag_ok, anti_ok;
    hit = 1'b0;
    diag_ok = 1'b1;
    anti_ok = 1'b1;
    for (int r = 0; r < N; r++) begin
      row_ok = 1'b1;
      col_ok = 1'b1;
      for (int c = 0; c < N; c++) begin
        row_ok = row_ok & (b[2*(r*N+c) +: 2] == p);
        col_ok = col_ok & (b[2*(c*N+r) +: 2] == p);
      end
      hit = hit | row_ok | col_ok;
      diag_ok = diag_ok & (b[2*(r*(N+1)) +: 2] == p);
      anti_ok = anti_ok & (b[2*((r+1)*(N-1)) +: 2] == p);
    end
    return hit | diag_ok | anti_ok;
  endfunction

  function automatic logic [2:0] legality(input logic go, input logic [1:0] pl,
                                          input logic [IDXW-1:0] idx, input logic [1:0] np,
                                          input logic [2*CELLS-1:0] b);
    logic occ;
    logic [2:0] err;
    occ = 1'b0;
    for (int i = 0; i < CELLS; i++) begin
      if (idx == IDXW'(i)) begin
        occ = (b[2*i +: 2] != 2'b00);
      end
    end
    if (go) begin
      err = ERR_OVER;
    end else if (pl == 2'b00 || pl == 2'b11) begin
      err = ERR_PLYR;
    end else if ({1'b0, idx} >= (IDXW+1)'(CELLS)) begin
      err = ERR_RANGE;
    end else if (pl != np) begin
      err = ERR_TURN;
    end else if (occ) begin
      err = ERR_OCC;
    end else begin
      err = ERR_OK;
    end
    return err;
  endfunction

  // Next-state logic: clear overrides everything; the flags for a move are
  // computed on the UPD edge so they land together with resp_valid in CHK.
  always_comb begin
    state_d       = state_q;
    board_d       = board_q;
    next_player_d = next_player_q;
    move_count_d  = move_count_q;
    is_full_d     = is_full_q;
    winner_d      = winner_q;
    game_over_d   = game_over_q;
    resp_valid_d  = 1'b0;
    resp_err_d    = resp_err_q;
    req_idx_d     = req_idx_q;
    req_player_d  = req_player_q;
    req_err_d     = req_err_q;
    if (clear) begin
      state_d       = S_IDLE;
      board_d       = '0;
      next_player_d = 2'b01;
      move_count_d  = '0;
      is_full_d     = 1'b0;
      winner_d      = 2'b00;
      game_over_d   = 1'b0;
      resp_err_d    = 3'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (move_valid) begin
            req_idx_d    = move_idx;
            req_player_d = move_player;
            req_err_d    = legality(game_over_q, move_player, move_idx, next_player_q, board_q);
            state_d      = S_UPD;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_UPD: begin
          if (req_err_q == ERR_OK) begin
            for (int i = 0; i < CELLS; i++) begin
              if (req_idx_q == IDXW'(i)) begin
                board_d[2*i +: 2] = req_player_q;
              end
            end
            next_player_d = (next_player_q == 2'b01) ? 2'b10 : 2'b01;
            move_count_d  = move_count_q + CW'(1);
            if (has_line(board_d, req_player_q)) begin
              winner_d = req_player_q;
            end else begin
              winner_d = winner_q;
            end
          end else begin
            winner_d = winner_q;
          end
          is_full_d    = (move_count_d == FULL_CNT);
          game_over_d  = (winner_d != 2'b00) || is_full_d;
          resp_valid_d = 1'b1;
          resp_err_d   = req_err_q;
          state_d      = S_CHK;
        end
        S_CHK: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      board_q       <= '0;
      next_player_q <= 2'b01;
      move_count_q  <= '0;
      is_full_q     <= 1'b0;
      winner_q      <= 2'b00;
      game_over_q   <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_err_q    <= 3'd0;
      req_idx_q     <= '0;
      req_player_q  <= 2'b00;
      req_err_q     <= 3'd0;
    end else begin
      state_q       <= state_d;
      board_q       <= board_d;
      next_player_q <= next_player_d;
      move_count_q  <= move_count_d;
      is_full_q     <= is_full_d;
      winner_q      <= winner_d;
      game_over_q   <= game_over_d;
      resp_valid_q  <= resp_valid_d;
      resp_err_q    <= resp_err_d;
      req_idx_q     <= req_idx_d;
      req_player_q  <= req_player_d;
      req_err_q     <= req_err_d;
    end
  end

  assign move_ready  = (state_q == S_IDLE);
  // A clear raised while the response is showing cancels that response.
  assign resp_valid  = resp_valid_q & ~clear;
  assign resp_err    = resp_err_q;
  assign board_flat  = board_q;
  assign next_player = next_player_q;
  assign move_count  = move_count_q;
  assign is_full     = is_full_q;
  assign winner      = winner_q;
  assign game_over   = game_over_q;

endmodule

// File: tb/tb_board_tracker.sv
// Scoreboard bench for board_tracker: directed moves on an N=3 and an N=4 instance.
module tb_board_tracker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic clear3, mv3, ready3, rv3, full3, go3;
  logic [3:0] idx3;
  logic [1:0] pl3, np3, win3;
  logic [2:0] err3;
  logic [17:0] bf3;
  logic [3:0] mc3;
  logic clear4, mv4, ready4, rv4, full4, go4;
  logic [3:0] idx4;
  logic [1:0] pl4, np4, win4;
  logic [2:0] err4;
  logic [31:0] bf4;
  logic [4:0] mc4;

  board_tracker #(.N(3)) u3 (
    .clk(clk), .rst_n(rst_n), .clear(clear3), .move_valid(mv3), .move_ready(ready3),
    .move_idx(idx3), .move_player(pl3), .resp_valid(rv3), .resp_err(err3),
    .board_flat(bf3), .next_player(np3), .move_count(mc3), .is_full(full3),
    .winner(win3), .game_over(go3));

  board_tracker #(.N(4)) u4 (
    .clk(clk), .rst_n(rst_n), .clear(clear4), .move_valid(mv4), .move_ready(ready4),
    .move_idx(idx4), .move_player(pl4), .resp_valid(rv4), .resp_err(err4),
    .board_flat(bf4), .next_player(np4), .move_count(mc4), .is_full(full4),
    .winner(win4), .game_over(go4));

  typedef struct {
    logic [2:0]  err;
    logic [31:0] board;
    logic [1:0]  np;
    int          cnt;
    logic        full;
    logic [1:0]  win;
    logic        go;
    int          cyc;
  } exp_t;

  exp_t q3[$];
  exp_t q4[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] m_board [2];
  logic [1:0]  m_np [2];
  int          m_cnt [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cmp(input string tag, input exp_t e, input logic [2:0] err, input logic [31:0] bd,
                     input logic [1:0] np, input int cnt, input logic full, input logic [1:0] win,
                     input logic go);
    chk({tag, " resp_err"}, 32'(err), 32'(e.err));
    chk({tag, " latency"}, 32'(cyc), 32'(e.cyc));
    chk({tag, " board"}, bd, e.board);
    chk({tag, " next_player"}, 32'(np), 32'(e.np));
    chk({tag, " move_count"}, 32'(cnt), 32'(e.cnt));
    chk({tag, " is_full"}, 32'(full), 32'(e.full));
    chk({tag, " winner"}, 32'(win), 32'(e.win));
    chk({tag, " game_over"}, 32'(go), 32'(e.go));
  endtask

  // Monitor: pop an expectation whenever a DUT presents a response.
  always @(negedge clk) begin
    exp_t e;
    if (rv3) begin
      if (q3.size() == 0) begin
        checks++; errors++;
        $display("FAIL n3 unexpected resp_valid at cycle %0d, required none", cyc);
      end else begin
        e = q3.pop_front();
        cmp("n3", e, err3, {14'b0, bf3}, np3, int'(mc3), full3, win3, go3);
      end
    end
    if (rv4) begin
      if (q4.size() == 0) begin
        checks++; errors++;
        $display("FAIL n4 unexpected resp_valid at cycle %0d, required none", cyc);
      end else begin
        e = q4.pop_front();
        cmp("n4", e, err4, bf4, np4, int'(mc4), full4, win4, go4);
      end
    end
  end

  function automatic logic rdy(input int s);
    return (s == 0) ? ready3 : ready4;
  endfunction

  function automatic int qsz(input int s);
    return (s == 0) ? q3.size() : q4.size();
  endfunction

  task automatic mreset(input int s);
    m_board[s] = 32'd0;
    m_np[s] = 2'b01;
    m_cnt[s] = 0;
  endtask

  // Issue one move; e_win/e_full are the hand-computed flags after the move.
  task automatic mv(input int s, input int idx, input logic [1:0] pl, input logic [2:0] e_err,
                    input logic [1:0] e_win, input logic e_full);
    exp_t e;
    int t;
    @(negedge clk);
    t = 0;
    while (!rdy(s) && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) begin
      checks++; errors++;
      $display("FAIL move_ready timeout: got 0 required 1");
    end
    if (s == 0) begin mv3 = 1'b1; idx3 = 4'(idx); pl3 = pl; end
    else        begin mv4 = 1'b1; idx4 = 4'(idx); pl4 = pl; end
    @(posedge clk);
    #1;
    if (e_err == 3'd0) begin
      m_board[s][2*idx +: 2] = pl;
      m_cnt[s]++;
      m_np[s] = (m_np[s] == 2'b01) ? 2'b10 : 2'b01;
    end
    e.err = e_err; e.board = m_board[s]; e.np = m_np[s]; e.cnt = m_cnt[s];
    e.full = e_full; e.win = e_win; e.go = (e_win != 2'b00) || e_full; e.cyc = cyc + 1;
    if (s == 0) q3.push_back(e); else q4.push_back(e);
    @(negedge clk);
    if (s == 0) begin mv3 = 1'b0; idx3 = ~idx3; pl3 = ~pl3; end
    else        begin mv4 = 1'b0; idx4 = ~idx4; pl4 = ~pl4; end
    chk("move_ready low in UPD", 32'(rdy(s)), 32'd0);
    t = 0;
    while (qsz(s) != 0 && t < 8) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (qsz(s) != 0) begin
      checks++; errors++;
      $display("FAIL resp timeout: got no resp_valid required one");
      if (s == 0) q3.delete(); else q4.delete();
    end else begin
      chk("move_ready low in CHK", 32'(rdy(s)), 32'd0);
    end
  endtask

  task automatic check_reset3(input string tag);
    chk({tag, " board"}, {14'b0, bf3}, 32'd0);
    chk({tag, " next_player"}, 32'(np3), 32'd1);
    chk({tag, " move_count"}, 32'(mc3), 32'd0);
    chk({tag, " flags"}, {29'b0, full3, go3, rv3}, 32'd0);
    chk({tag, " winner"}, 32'(win3), 32'd0);
  endtask

  task automatic do_clear3();
    @(negedge clk);
    clear3 = 1'b1;
    @(posedge clk);
    #1;
    clear3 = 1'b0;
    check_reset3("clear");
    mreset(0);
  endtask

  initial begin
    rst_n = 1'b0;
    clear3 = 1'b0; mv3 = 1'b0; idx3 = 4'd0; pl3 = 2'b00;
    clear4 = 1'b0; mv4 = 1'b0; idx4 = 4'd0; pl4 = 2'b00;
    mreset(0);
    mreset(1);
    repeat (2) @(negedge clk);
    check_reset3("reset");
    chk("reset move_ready", 32'(ready3), 32'd1);
    chk("reset resp_err", 32'(err3), 32'd0);
    rst_n = 1'b1;

    // Basic move, turn, occupancy, range and player-code errors.
    mv(0, 0, 2'b01, 3'd0, 2'b00, 1'b0);
    mv(0, 1, 2'b01, 3'd3, 2'b00, 1'b0);
    mv(0, 4, 2'b10, 3'd0, 2'b00, 1'b0);
    mv(0, 4, 2'b01, 3'd1, 2'b00, 1'b0);
    mv(0, 9, 2'b01, 3'd2, 2'b00, 1'b0);
    mv(0, 2, 2'b11, 3'd4, 2'b00, 1'b0);
    mv(0, 2, 2'b00, 3'd4, 2'b00, 1'b0);
    mv(0, 15, 2'b10, 3'd2, 2'b00, 1'b0);

    // Row win for P1, then game-over lockout.
    do_clear3();
    mv(0, 0, 2'b01, 3'd0, 2'b00, 1'b0);
    mv(0, 3, 2'b10, 3'd0, 2'b00, 1'b0);
    mv(0, 1, 2'b01, 3'd0, 2'b00, 1'b0);
    mv(0, 4, 2'b10, 3'd0, 2'b00, 1'b0);
    mv(0, 2, 2'b01, 3'd0, 2'b01, 1'b0);
    mv(0, 5, 2'b10, 3'd5, 2'b01, 1'b0);

    // Draw: board fills with no line.
    do_clear3();
    mv(0, 0, 2'b01, 3'd0, 2'b00, 1'b0);
    mv(0, 1, 2'b10, 3'd0, 2'b00, 1'b0);
    mv(0, 2, 2'b01, 3'd0, 2'b00, 1'b0);
    mv(0, 4, 2'b10, 3'd0, 2'b00, 1'b0);
    mv(0, 3, 2'b01, 3'd0, 2'b00, 1'b0);
    mv(0, 5, 2'b10, 3'd0, 2'b00, 1'b0);
    mv(0, 7, 2'b01, 3'd0, 2'b00, 1'b0);
    mv(0, 6, 2'b10, 3'd0, 2'b00, 1'b0);
    mv(0, 8, 2'b01, 3'd0, 2'b00, 1'b1);
    chk("draw move_count", 32'(mc3), 32'd9);
    mv(0, 9, 2'b11, 3'd5, 2'b00, 1'b1);

    // Clear during UPD aborts the move with no response.
    do_clear3();
    @(negedge clk);
    mv3 = 1'b1; idx3 = 4'd0; pl3 = 2'b01;
    @(posedge clk);
    @(negedge clk);
    mv3 = 1'b0;
    clear3 = 1'b1;
    @(posedge clk);
    #1;
    clear3 = 1'b0;
    check_reset3("clear in UPD");
    repeat (3) @(negedge clk);
    chk("after abort move_ready", 32'(ready3), 32'd1);

    // Clear together with move_valid in IDLE: the move is not taken.
    @(negedge clk);
    mv3 = 1'b1; idx3 = 4'd4; pl3 = 2'b01; clear3 = 1'b1;
    @(posedge clk);
    #1;
    mv3 = 1'b0; clear3 = 1'b0;
    chk("clear beats move: move_ready", 32'(ready3), 32'd1);
    check_reset3("clear beats move");

    // Async reset while the response is showing in CHK.
    @(negedge clk);
    mv3 = 1'b1; idx3 = 4'd4; pl3 = 2'b01;
    @(posedge clk);
    @(negedge clk);
    mv3 = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset3("async reset in CHK");
    @(negedge clk);
    rst_n = 1'b1;
    mreset(0);
    mreset(1);

    // N=4 anti-diagonal win for P2.
    mv(1, 0, 2'b01, 3'd0, 2'b00, 1'b0);
    mv(1, 3, 2'b10, 3'd0, 2'b00, 1'b0);
    mv(1, 1, 2'b01, 3'd0, 2'b00, 1'b0);
    mv(1, 6, 2'b10, 3'd0, 2'b00, 1'b0);
    mv(1, 2, 2'b01, 3'd0, 2'b00, 1'b0);
    mv(1, 9, 2'b10, 3'd0, 2'b00, 1'b0);
    mv(1, 4, 2'b01, 3'd0, 2'b00, 1'b0);
    mv(1, 12, 2'b10, 3'd0, 2'b10, 1'b0);
    mv(1, 5, 2'b01, 3'd5, 2'b10, 1'b0);

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
